// File: rtl/hps_ext_cmdq.sv
// hps_ext_cmdq - HPS EXT_BUS command decoder with a DEPTH-entry blit command queue.
// Decodes the 16-bit word protocol, returns status snapshots, and buffers
// PUSH_BLIT requests for the LZ4/blit engine.
// Optional feature: define HPS_EXT_CMDQ_DEBUG_EN to add GET_DEBUG (CMD_BASE+5)
// with wrapping push/pop counters.
module hps_ext_cmdq #(
  parameter int CMD_BASE = 'hF0,
  parameter int DEPTH    = 4,
  parameter int SIZE_W   = 32
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  inout  wire  [35:0]       EXT_BUS,
  input  logic [31:0]       vga_frame,
  input  logic [15:0]       vga_vcount,
  input  logic [7:0]        status_flags,
  output logic              cmd_init,
  output logic [5:0]        init_mode,
  output logic              q_valid,
  input  logic              q_ready,
  output logic              q_ab,
  output logic [SIZE_W-1:0] q_size,
  output logic [1:0]        q_field,
  output logic              q_drop
);

  localparam int AW   = $clog2(DEPTH);
  localparam int HI_W = SIZE_W - 16;
  localparam logic [15:0] LP_BASE = 16'(CMD_BASE);
`ifdef HPS_EXT_CMDQ_DEBUG_EN
  localparam logic [15:0] LP_LAST = 16'd5;
`else
  localparam logic [15:0] LP_LAST = 16'd4;
`endif

  // EXT_BUS split into its directional fields
  logic [15:0] w_io_din;
  logic        w_io_strobe;
  logic        w_io_enable;
  logic        w_unused_bus;
  logic [15:0] r_io_dout;
  logic        r_dout_en;

  assign w_io_din     = EXT_BUS[31:16];
  assign w_io_strobe  = EXT_BUS[33];
  assign w_io_enable  = EXT_BUS[34];
  assign w_unused_bus = EXT_BUS[35];
  assign EXT_BUS[15:0] = r_io_dout;
  assign EXT_BUS[32]   = r_dout_en;

  // Transfer framing and command state
  logic [4:0]  r_byte_cnt;
  logic        r_cmd_vld;
  logic [2:0]  r_cmd_off;
  logic [15:0] w_cmd_diff;
  logic        w_cmd_hit;
  logic        w_word;

  // GET_STATUS snapshot (frame[15:0] is returned live at w1, so only the top half is kept)
  logic [15:0] r_snap_frame_hi;
  logic [15:0] r_snap_vcount;
  logic [7:0]  r_snap_flags;
  logic [4:0]  r_snap_level;
  logic [7:0]  r_snap_drop;

  // Init and push staging
  logic              r_cmd_init;
  logic [5:0]        r_init_mode;
  logic              r_stg_ab;
  logic [SIZE_W-1:0] r_stg_size;

  // Queue storage and pointers
  logic              r_mem_ab    [DEPTH];
  logic [SIZE_W-1:0] r_mem_size  [DEPTH];
  logic [1:0]        r_mem_field [DEPTH];
  logic [AW:0]       r_wr_ptr;
  logic [AW:0]       r_rd_ptr;
  logic [AW:0]       w_fill;
  logic [4:0]        w_level;
  logic              w_empty;
  logic              w_full;
  logic              w_pop;
  logic              w_push_ok;
  logic [7:0]        r_drop_cnt;
  logic              r_q_drop;

  // Decoder strobes
  logic [15:0] w_dout_nxt;
  logic        w_push;
  logic        w_flush;
  logic        w_clr_drop;
  logic        w_snap;

`ifdef HPS_EXT_CMDQ_DEBUG_EN
  logic [15:0] r_push_cnt;
  logic [15:0] r_pop_cnt;
  logic [15:0] r_snap_pop;
  logic        w_dbg_snap;
`endif

  assign w_cmd_diff = w_io_din - LP_BASE;
  assign w_cmd_hit  = (w_io_din >= LP_BASE) && (w_cmd_diff <= LP_LAST);
  // data word of an accepted command (word 0 is the opcode itself)
  assign w_word     = w_io_enable && w_io_strobe && r_cmd_vld && (r_byte_cnt != 5'd0);

  assign w_empty   = (r_wr_ptr == r_rd_ptr);
  assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_fill    = r_wr_ptr - r_rd_ptr;
  assign w_level   = 5'(w_fill);
  assign w_pop     = !w_empty && q_ready;
  assign w_push_ok = w_push && (!w_full || w_pop);

  assign q_valid   = !w_empty;
  assign q_ab      = r_mem_ab[r_rd_ptr[AW-1:0]];
  assign q_size    = r_mem_size[r_rd_ptr[AW-1:0]];
  assign q_field   = r_mem_field[r_rd_ptr[AW-1:0]];
  assign q_drop    = r_q_drop;
  assign cmd_init  = r_cmd_init;
  assign init_mode = r_init_mode;

  // Word decode: next io_dout value and per-command action strobes
  always_comb begin
    w_dout_nxt = 16'd0;
    w_push     = 1'b0;
    w_flush    = 1'b0;
    w_clr_drop = 1'b0;
    w_snap     = 1'b0;
`ifdef HPS_EXT_CMDQ_DEBUG_EN
    w_dbg_snap = 1'b0;
`endif
    if (w_io_enable && w_io_strobe && (r_byte_cnt == 5'd0)) begin
      if (w_cmd_hit) begin
        w_dout_nxt = {w_level, 3'b000, r_drop_cnt};
      end else begin
        w_dout_nxt = 16'd0;
      end
    end else if (w_word) begin
      case (r_cmd_off)
        3'd0: begin
          case (r_byte_cnt)
            5'd1: begin
              w_snap     = 1'b1;
              w_dout_nxt = vga_frame[15:0];
            end
            5'd2:    w_dout_nxt = r_snap_frame_hi;
            5'd3:    w_dout_nxt = r_snap_vcount;
            5'd4:    w_dout_nxt = {3'b000, r_snap_level, r_snap_flags};
            5'd5:    w_dout_nxt = {8'd0, r_snap_drop};
            default: w_dout_nxt = 16'd0;
          endcase
        end
        3'd2:    w_push  = (r_byte_cnt == 5'd4);
        3'd3:    w_flush = (r_byte_cnt == 5'd1) && w_io_din[0];
        3'd4: begin
          if (r_byte_cnt == 5'd1) begin
            w_dout_nxt = {w_level, 3'b000, r_drop_cnt};
            w_clr_drop = w_io_din[0];
          end else begin
            w_dout_nxt = 16'd0;
          end
        end
`ifdef HPS_EXT_CMDQ_DEBUG_EN
        3'd5: begin
          case (r_byte_cnt)
            5'd1: begin
              w_dbg_snap = 1'b1;
              w_dout_nxt = r_push_cnt;
            end
            5'd2:    w_dout_nxt = r_snap_pop;
            default: w_dout_nxt = 16'd0;
          endcase
        end
`endif
        default: w_dout_nxt = 16'd0;
      endcase
    end else begin
      w_dout_nxt = 16'd0;
    end
  end

  // Transfer framing: word counter, latched command, registered bus outputs
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_byte_cnt <= 5'd0;
      r_cmd_vld  <= 1'b0;
      r_cmd_off  <= 3'd0;
      r_io_dout  <= 16'd0;
      r_dout_en  <= 1'b0;
    end else if (!w_io_enable) begin
      r_byte_cnt <= 5'd0;
      r_cmd_vld  <= 1'b0;
      r_cmd_off  <= 3'd0;
      r_io_dout  <= 16'd0;
      r_dout_en  <= 1'b0;
    end else if (w_io_strobe) begin
      r_io_dout <= w_dout_nxt;
      if (r_byte_cnt != 5'd31) begin
        r_byte_cnt <= r_byte_cnt + 5'd1;
      end
      if (r_byte_cnt == 5'd0) begin
        r_cmd_vld <= w_cmd_hit;
        r_cmd_off <= w_cmd_diff[2:0];
        r_dout_en <= w_cmd_hit;
      end
    end
  end

  // Command side effects: init level/mode, push staging, status snapshot
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_cmd_init      <= 1'b0;
      r_init_mode     <= 6'd0;
      r_stg_ab        <= 1'b0;
      r_stg_size      <= '0;
      r_snap_frame_hi <= 16'd0;
      r_snap_vcount   <= 16'd0;
      r_snap_flags    <= 8'd0;
      r_snap_level    <= 5'd0;
      r_snap_drop     <= 8'd0;
    end else if (w_word) begin
      if ((r_cmd_off == 3'd1) && (r_byte_cnt == 5'd1)) begin
        r_cmd_init  <= w_io_din[0];
        r_init_mode <= 6'd0;
      end else if ((r_cmd_off == 3'd1) && (r_byte_cnt == 5'd2)) begin
        r_init_mode <= w_io_din[5:0];
      end else if ((r_cmd_off == 3'd2) && (r_byte_cnt == 5'd1)) begin
        r_stg_ab <= w_io_din[0];
      end else if ((r_cmd_off == 3'd2) && (r_byte_cnt == 5'd2)) begin
        r_stg_size[15:0] <= w_io_din;
      end else if ((r_cmd_off == 3'd2) && (r_byte_cnt == 5'd3)) begin
        r_stg_size[SIZE_W-1:16] <= w_io_din[HI_W-1:0];
      end
      if (w_snap) begin
        r_snap_frame_hi <= vga_frame[31:16];
        r_snap_vcount   <= vga_vcount;
        r_snap_flags    <= status_flags;
        r_snap_level    <= w_level;
        r_snap_drop     <= r_drop_cnt;
      end
    end
  end

  // Queue: push/pop/flush pointers, entry storage, overflow accounting
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_drop_cnt <= 8'd0;
      r_q_drop   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem_ab[i]    <= 1'b0;
        r_mem_size[i]  <= '0;
        r_mem_field[i] <= 2'd0;
      end
    end else begin
      r_q_drop <= w_push && w_full && !w_pop;
      // a flush wins over a concurrent pop: the handshake completes, queue ends empty
      if (w_flush) begin
        r_rd_ptr <= r_wr_ptr;
      end else if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_push_ok) begin
        r_mem_ab[r_wr_ptr[AW-1:0]]    <= r_stg_ab;
        r_mem_size[r_wr_ptr[AW-1:0]]  <= r_stg_size;
        r_mem_field[r_wr_ptr[AW-1:0]] <= w_io_din[1:0];
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_clr_drop) begin
        r_drop_cnt <= 8'd0;
      end else if (w_push && w_full && !w_pop && (r_drop_cnt != 8'hFF)) begin
        r_drop_cnt <= r_drop_cnt + 8'd1;
      end
    end
  end

`ifdef HPS_EXT_CMDQ_DEBUG_EN
  // Debug counters: wrapping accepted-push and pop counts, pop count snapshotted at w1
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_push_cnt <= 16'd0;
      r_pop_cnt  <= 16'd0;
      r_snap_pop <= 16'd0;
    end else begin
      if (w_push_ok) begin
        r_push_cnt <= r_push_cnt + 16'd1;
      end
      if (w_pop) begin
        r_pop_cnt <= r_pop_cnt + 16'd1;
      end
      if (w_dbg_snap) begin
        r_snap_pop <= r_pop_cnt;
      end
    end
  end
`endif

endmodule

// File: tb/tb_hps_ext_cmdq.sv
// tb_hps_ext_cmdq - self-checking bench for hps_ext_cmdq (DEPTH=4, SIZE_W=32).
module tb_hps_ext_cmdq;

  localparam int DEPTH = 4;
  localparam logic [15:0] OP_BASE = 16'h00F0;

  typedef struct {
    logic        ab;
    logic [31:0] size;
    logic [1:0]  field;
  } ent_t;

  typedef struct {
    string       nm;
    logic [15:0] dout;
    logic        en;
  } exp_t;

  typedef struct {
    logic [31:0]       frame;
    logic [15:0]       vcount;
    logic [7:0]        flags;
    logic [0:5][15:0]  exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] tb_din;
  logic        tb_strobe;
  logic        tb_enable;
  logic [31:0] vga_frame;
  logic [15:0] vga_vcount;
  logic [7:0]  status_flags;
  logic        q_ready;
  logic        cmd_init;
  logic [5:0]  init_mode;
  logic        q_valid;
  logic        q_ab;
  logic [31:0] q_size;
  logic [1:0]  q_field;
  logic        q_drop;
  wire  [35:0] ext_bus;
  wire  [15:0] io_dout;
  wire         dout_en;

  assign ext_bus[31:16] = tb_din;
  assign ext_bus[33]    = tb_strobe;
  assign ext_bus[34]    = tb_enable;
  assign ext_bus[35]    = 1'b0;
  assign io_dout        = ext_bus[15:0];
  assign dout_en        = ext_bus[32];

  hps_ext_cmdq #(.CMD_BASE('hF0), .DEPTH(DEPTH), .SIZE_W(32)) dut (
    .clk_sys      (clk),
    .reset_n      (reset_n),
    .EXT_BUS      (ext_bus),
    .vga_frame    (vga_frame),
    .vga_vcount   (vga_vcount),
    .status_flags (status_flags),
    .cmd_init     (cmd_init),
    .init_mode    (init_mode),
    .q_valid      (q_valid),
    .q_ready      (q_ready),
    .q_ab         (q_ab),
    .q_size       (q_size),
    .q_field      (q_field),
    .q_drop       (q_drop)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad   = 0;
  ent_t        mq[$];
  exp_t        sb[$];
  int          tb_push = 0;
  int          tb_pop  = 0;
  logic [7:0]  tb_drop = 8'd0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%h required=%h", nm, act, req);
    end
  endtask

  task automatic check_head(input string nm);
    if (mq.size() == 0) begin
      check({nm, "_valid"}, 32'(q_valid), 32'd0);
    end else begin
      check({nm, "_valid"}, 32'(q_valid), 32'd1);
      check({nm, "_ab"}, 32'(q_ab), 32'(mq[0].ab));
      check({nm, "_size"}, q_size, mq[0].size);
      check({nm, "_field"}, 32'(q_field), 32'(mq[0].field));
    end
  endtask

  // one strobed word; optional expectation and optional q_ready pulse on the same edge
  task automatic word(input logic [15:0] din, input bit chk, input logic [15:0] ed,
                      input logic ee, input string nm, input bit with_pop);
    exp_t e;
    @(negedge clk);
    if (with_pop) begin
      check_head({nm, "_head"});
      mq.delete(0);
      tb_pop++;
      q_ready = 1'b1;
    end
    tb_din    = din;
    tb_strobe = 1'b1;
    if (chk) sb.push_back('{nm, ed, ee});
    @(negedge clk);
    tb_strobe = 1'b0;
    q_ready   = 1'b0;
    if (chk) begin
      e = sb.pop_front();
      check({e.nm, "_dout"}, 32'(io_dout), 32'(e.dout));
      check({e.nm, "_en"}, 32'(dout_en), 32'(e.en));
    end
  endtask

  task automatic xfer_begin();
    @(negedge clk);
    tb_enable = 1'b1;
    tb_strobe = 1'b0;
  endtask

  task automatic xfer_end();
    @(negedge clk);
    tb_enable = 1'b0;
    tb_strobe = 1'b0;
    tb_din    = 16'd0;
    @(negedge clk);
  endtask

  function automatic logic [15:0] qstat();
    return {5'(mq.size()), 3'b000, tb_drop};
  endfunction

  task automatic push(input logic ab, input logic [31:0] sz, input logic [1:0] fld,
                      input bit pop_now, input string nm);
    bit   acc;
    ent_t n;
    acc = (mq.size() < DEPTH) || pop_now;
    xfer_begin();
    word(OP_BASE + 16'd2, 1'b1, qstat(), 1'b1, {nm, "_w0"}, 1'b0);
    word({15'd0, ab}, 1'b0, 16'd0, 1'b0, nm, 1'b0);
    word(sz[15:0], 1'b0, 16'd0, 1'b0, nm, 1'b0);
    word(sz[31:16], 1'b0, 16'd0, 1'b0, nm, 1'b0);
    check_head({nm, "_pre"});
    word({14'd0, fld}, 1'b0, 16'd0, 1'b0, nm, pop_now);
    check({nm, "_drop"}, 32'(q_drop), acc ? 32'd0 : 32'd1);
    if (acc) begin
      n.ab = ab; n.size = sz; n.field = fld;
      mq.push_back(n);
      tb_push++;
    end else if (tb_drop != 8'hFF) begin
      tb_drop = tb_drop + 8'd1;
    end
    check_head({nm, "_post"});
    xfer_end();
    check({nm, "_dropclr"}, 32'(q_drop), 32'd0);
  endtask

  task automatic get_queue(input logic clr, input string nm);
    logic [15:0] e0;
    e0 = qstat();
    xfer_begin();
    word(OP_BASE + 16'd4, 1'b1, e0, 1'b1, {nm, "_w0"}, 1'b0);
    word({15'd0, clr}, 1'b1, e0, 1'b1, {nm, "_w1"}, 1'b0);
    if (clr) tb_drop = 8'd0;
    xfer_end();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[4];
    vt[0] = '{32'h12345678, 16'h00F0, 8'hA5,
              {16'h0000, 16'h5678, 16'h1234, 16'h00F0, 16'h00A5, 16'h0000}};
    vt[1] = '{32'hFFFFFFFF, 16'hFFFF, 8'hFF,
              {16'h0000, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h00FF, 16'h0000}};
    vt[2] = '{32'h00000000, 16'h0000, 8'h00,
              {16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000}};
    vt[3] = '{32'hA5A55A5A, 16'h0123, 8'h3C,
              {16'h0000, 16'h5A5A, 16'hA5A5, 16'h0123, 16'h003C, 16'h0000}};

    reset_n = 1'b0; tb_din = 16'd0; tb_strobe = 1'b0; tb_enable = 1'b0;
    vga_frame = 32'd0; vga_vcount = 16'd0; status_flags = 8'd0; q_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_dout", 32'(io_dout), 32'd0);
    check("rst_en", 32'(dout_en), 32'd0);
    check("rst_valid", 32'(q_valid), 32'd0);
    check("rst_size", q_size, 32'd0);
    check("rst_ab", 32'(q_ab), 32'd0);
    check("rst_field", 32'(q_field), 32'd0);
    check("rst_drop", 32'(q_drop), 32'd0);
    check("rst_init", 32'(cmd_init), 32'd0);
    check("rst_mode", 32'(init_mode), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // GET_STATUS vectors; inputs inverted after w1 must not leak into w2..w5
    for (int i = 0; i < 4; i++) begin
      vga_frame = vt[i].frame; vga_vcount = vt[i].vcount; status_flags = vt[i].flags;
      xfer_begin();
      word(OP_BASE, 1'b1, vt[i].exp[0], 1'b1, $sformatf("st%0d_w0", i), 1'b0);
      word(16'd0, 1'b1, vt[i].exp[1], 1'b1, $sformatf("st%0d_w1", i), 1'b0);
      vga_frame = ~vt[i].frame; vga_vcount = ~vt[i].vcount; status_flags = ~vt[i].flags;
      for (int w = 2; w < 6; w++)
        word(16'd0, 1'b1, vt[i].exp[w], 1'b1, $sformatf("st%0d_w%0d", i, w), 1'b0);
      xfer_end();
    end

    // opcode below the command range
    xfer_begin();
    word(16'h00EF, 1'b1, 16'd0, 1'b0, "oor_w0", 1'b0);
    word(16'h1234, 1'b1, 16'd0, 1'b0, "oor_w1", 1'b0);
    xfer_end();

    // SET_INIT
    xfer_begin();
    word(OP_BASE + 16'd1, 1'b0, 16'd0, 1'b0, "init", 1'b0);
    word(16'h0001, 1'b0, 16'd0, 1'b0, "init", 1'b0);
    check("init_w1_bit", 32'(cmd_init), 32'd1);
    check("init_w1_mode", 32'(init_mode), 32'd0);
    word(16'h3F15, 1'b0, 16'd0, 1'b0, "init", 1'b0);
    check("init_w2_mode", 32'(init_mode), 32'h15);
    xfer_end();
    xfer_begin();
    word(OP_BASE + 16'd1, 1'b0, 16'd0, 1'b0, "init2", 1'b0);
    word(16'h0000, 1'b0, 16'd0, 1'b0, "init2", 1'b0);
    check("init2_bit", 32'(cmd_init), 32'd0);
    check("init2_mode", 32'(init_mode), 32'd0);
    xfer_end();

    // first push, then an aborted push
    push(1'b1, 32'h0001_2000, 2'd1, 1'b0, "push0");
    xfer_begin();
    word(OP_BASE + 16'd2, 1'b0, 16'd0, 1'b0, "abort", 1'b0);
    word(16'h0000, 1'b0, 16'd0, 1'b0, "abort", 1'b0);
    word(16'hBEEF, 1'b0, 16'd0, 1'b0, "abort", 1'b0);
    word(16'h0003, 1'b0, 16'd0, 1'b0, "abort", 1'b0);
    xfer_end();
    check_head("abort");
    get_queue(1'b0, "gq_abort");

    // fill and overflow: the fifth entry is dropped
    for (int i = 1; i < 5; i++)
      push(i[0], 32'h00A0_0000 + 32'h0000_0100 * i, 2'(i), 1'b0, $sformatf("push%0d", i));
    get_queue(1'b0, "gq_full");

    // push on full with simultaneous pop, wrapping pointers over 3*DEPTH entries
    for (int i = 0; i < 3 * DEPTH; i++)
      push(1'($urandom_range(0, 1)), $urandom, 2'($urandom_range(0, 3)), 1'b1,
           $sformatf("wrap%0d", i));
    get_queue(1'b0, "gq_wrap");

    // drain one entry with a lone q_ready pulse
    @(negedge clk);
    check_head("pop1_pre");
    mq.delete(0);
    tb_pop++;
    q_ready = 1'b1;
    @(negedge clk);
    q_ready = 1'b0;
    check_head("pop1_post");

    // FLUSH with a concurrent pop
    xfer_begin();
    word(OP_BASE + 16'd3, 1'b0, 16'd0, 1'b0, "flush", 1'b0);
    word(16'h0001, 1'b0, 16'd0, 1'b0, "flush", 1'b1);
    mq.delete();
    check_head("flush_post");
    xfer_end();
    check_head("flush_idle");
    get_queue(1'b1, "gq_clr");
    get_queue(1'b0, "gq_after");

`ifdef HPS_EXT_CMDQ_DEBUG_EN
    xfer_begin();
    word(OP_BASE + 16'd5, 1'b1, qstat(), 1'b1, "dbg_w0", 1'b0);
    word(16'd0, 1'b1, 16'(tb_push), 1'b1, "dbg_w1", 1'b0);
    word(16'd0, 1'b1, 16'(tb_pop), 1'b1, "dbg_w2", 1'b0);
    xfer_end();
`else
    xfer_begin();
    word(OP_BASE + 16'd5, 1'b1, 16'd0, 1'b0, "dbg_w0", 1'b0);
    word(16'd0, 1'b1, 16'd0, 1'b0, "dbg_w1", 1'b0);
    xfer_end();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
